// File: rtl/app_mul_pipe.sv
// Three-stage pipelined Mitchell logarithmic multiplier with valid/ready handshake,
// signed magnitude handling, error correction, exact bypass and unsigned saturation.
module app_mul_pipe #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CORR_FRAC = WIDTH'(32'h0A00_0000),
  parameter int               TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [2:0]             in_mode,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_approx
);

  localparam int LW = $clog2(WIDTH);
  localparam int KW = $clog2(2*WIDTH+1);
  localparam int PW = 3*WIDTH+2;

  function automatic logic [LW-1:0] lod(input logic [WIDTH-1:0] v);
    lod = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lod = LW'(i);
  endfunction

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // stage 1: magnitude, zero detect, leading-one normalisation
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [LW-1:0]    ka_c, kb_c;
  logic [WIDTH-2:0] fa_c, fb_c;

  assign mag_a = (in_mode[0] && in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b = (in_mode[0] && in_b[WIDTH-1]) ? -in_b : in_b;
  assign ka_c  = lod(mag_a);
  assign kb_c  = lod(mag_b);
  assign fa_c  = (WIDTH-1)'(mag_a << (LW'(WIDTH-1) - ka_c));
  assign fb_c  = (WIDTH-1)'(mag_b << (LW'(WIDTH-1) - kb_c));

  logic                 s1_valid, s1_z, s1_neg, s1_exact, s1_signed, s1_corr_en;
  logic [WIDTH-1:0]     s1_mag_a, s1_mag_b;
  logic [LW-1:0]        s1_ka, s1_kb;
  logic [WIDTH-2:0]     s1_fa, s1_fb;
  logic [TAG_WIDTH-1:0] s1_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_z       <= 1'b0;
      s1_neg     <= 1'b0;
      s1_exact   <= 1'b0;
      s1_signed  <= 1'b0;
      s1_corr_en <= 1'b0;
      s1_mag_a   <= '0;
      s1_mag_b   <= '0;
      s1_ka      <= '0;
      s1_kb      <= '0;
      s1_fa      <= '0;
      s1_fb      <= '0;
      s1_tag     <= '0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_z       <= (mag_a == '0) || (mag_b == '0);
      s1_neg     <= in_mode[0] && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      s1_exact   <= in_mode[2];
      s1_signed  <= in_mode[0];
      s1_corr_en <= in_mode[1];
      s1_mag_a   <= mag_a;
      s1_mag_b   <= mag_b;
      s1_ka      <= ka_c;
      s1_kb      <= kb_c;
      s1_fa      <= fa_c;
      s1_fb      <= fb_c;
      s1_tag     <= in_tag;
    end
  end

  // stage 2: log-domain add with optional correction, exact multiply
  logic [WIDTH-1:0]   s_sum, corr;
  logic               carry, m_ovf;
  logic [WIDTH:0]     m_sum, m_c;
  logic [KW-1:0]      k_c;
  logic [2*WIDTH-1:0] exact_c;

  assign s_sum   = {1'b0, s1_fa} + {1'b0, s1_fb};
  assign carry   = s_sum[WIDTH-1];
  assign corr    = !s1_corr_en ? '0 : (carry ? (CORR_FRAC >> 1) : CORR_FRAC);
  assign m_sum   = {2'b01, s_sum[WIDTH-2:0]} + {1'b0, corr};
  assign m_ovf   = m_sum[WIDTH];
  assign m_c     = m_ovf ? (m_sum >> 1) : m_sum;
  assign k_c     = KW'(s1_ka) + KW'(s1_kb) + KW'(carry) + KW'(m_ovf);
  assign exact_c = {{WIDTH{1'b0}}, s1_mag_a} * {{WIDTH{1'b0}}, s1_mag_b};

  logic                 s2_valid, s2_z, s2_neg, s2_exact, s2_signed;
  logic [WIDTH:0]       s2_m;
  logic [KW-1:0]        s2_k;
  logic [2*WIDTH-1:0]   s2_exact_prod;
  logic [TAG_WIDTH-1:0] s2_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid      <= 1'b0;
      s2_z          <= 1'b0;
      s2_neg        <= 1'b0;
      s2_exact      <= 1'b0;
      s2_signed     <= 1'b0;
      s2_m          <= '0;
      s2_k          <= '0;
      s2_exact_prod <= '0;
      s2_tag        <= '0;
    end else if (advance) begin
      s2_valid      <= s1_valid;
      s2_z          <= s1_z;
      s2_neg        <= s1_neg;
      s2_exact      <= s1_exact;
      s2_signed     <= s1_signed;
      s2_m          <= m_c;
      s2_k          <= k_c;
      s2_exact_prod <= exact_c;
      s2_tag        <= s1_tag;
    end
  end

  // stage 3: antilog shift, saturation, zero force, sign restore
  logic [PW-1:0]      wide, p_full;
  logic               sat;
  logic [2*WIDTH-1:0] p_apx, p_mag, p_out;

  assign wide   = PW'(s2_m) << s2_k;
  assign p_full = wide >> (WIDTH-1);
  assign sat    = !s2_signed && (|p_full[PW-1:2*WIDTH]);
  assign p_apx  = sat ? '1 : p_full[2*WIDTH-1:0];
  assign p_mag  = s2_z ? '0 : (s2_exact ? s2_exact_prod : p_apx);
  assign p_out  = s2_neg ? -p_mag : p_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
      out_approx  <= 1'b0;
    end else if (advance) begin
      out_valid   <= s2_valid;
      out_product <= p_out;
      out_tag     <= s2_tag;
      out_approx  <= !s2_exact;
    end
  end

endmodule

// File: tb/tb_app_mul_pipe.sv
// Directed self-checking bench for app_mul_pipe (WIDTH=32, TAG_WIDTH=4).
module tb_app_mul_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic [3:0]  out_tag;
  logic        out_approx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  app_mul_pipe #(.WIDTH(32), .CORR_FRAC(32'h0A00_0000), .TAG_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag), .out_approx(out_approx)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Called at posedge+1 with an empty pipeline; checks latency and the result.
  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] mode, input logic [3:0] tag, input logic [63:0] exp);
    int cyc;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'd3);
    chk({name, " product"}, out_product, exp);
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    chk({name, " approx"}, 64'(out_approx), 64'(!mode[2]));
    @(posedge clk); #1;
  endtask

  logic [63:0] held;
  logic        held_v;
  int          sent, recv, cyc, extra;
  logic        saw_block;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b1;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_product", out_product, 64'd0);
    chk("reset out_tag", 64'(out_tag), 64'd0);
    chk("reset out_approx", 64'(out_approx), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    run_one("3x5 m010", 32'd3, 32'd5, 3'b010, 4'd1, 64'd14);
    run_one("3x5 m000", 32'd3, 32'd5, 3'b000, 4'd2, 64'd14);
    run_one("3x5 m100", 32'd3, 32'd5, 3'b100, 4'd3, 64'd15);
    run_one("3x3 m010", 32'd3, 32'd3, 3'b010, 4'd4, 64'd8);
    run_one("4x8 m000", 32'd4, 32'd8, 3'b000, 4'd5, 64'd32);
    run_one("4x8 m010", 32'd4, 32'd8, 3'b010, 4'd6, 64'd34);
    run_one("-3x5 m101", 32'hFFFF_FFFD, 32'd5, 3'b101, 4'd7, 64'hFFFF_FFFF_FFFF_FFF1);
    run_one("-3x5 m001", 32'hFFFF_FFFD, 32'd5, 3'b001, 4'd8, 64'hFFFF_FFFF_FFFF_FFF2);
    run_one("0x-7 m011", 32'd0, 32'hFFFF_FFF9, 3'b011, 4'd9, 64'd0);
    run_one("0x5 m010", 32'd0, 32'd5, 3'b010, 4'd10, 64'd0);
    run_one("max sat m010", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("max exact m100", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 4'd12, 64'hFFFF_FFFE_0000_0001);
    run_one("-1x-1 m001", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 4'd13, 64'd1);
    run_one("minxmin m001", 32'h8000_0000, 32'h8000_0000, 3'b001, 4'd14, 64'h4000_0000_0000_0000);

    // back-to-back stream of exact products (i+2)*3 with a consumer stall
    sent = 0; recv = 0; cyc = 0; held = '0; held_v = 1'b0; saw_block = 1'b0;
    while (recv < 8 && cyc < 40) begin
      in_valid  = (sent < 8);
      in_a      = 32'(sent + 2);
      in_b      = 32'd3;
      in_mode   = 3'b100;
      in_tag    = 4'(sent);
      out_ready = !(cyc >= 2 && cyc < 6);
      @(negedge clk);
      chk("in_ready follows advance", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && !out_ready) begin
        if (held_v) chk("stall holds product", out_product, held);
        held = out_product;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (!in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("stream tag", 64'(out_tag), 64'(recv));
        chk("stream product", out_product, 64'((recv + 2) * 3));
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream sent", 64'(sent), 64'd8);
    chk("stream received", 64'(recv), 64'd8);
    chk("stream in_ready dropped", 64'(saw_block), 64'd1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream no duplicates", 64'(extra), 64'd0);

    // reset with three transactions in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'd7; in_b = 32'(i + 1); in_mode = 3'b100; in_tag = 4'(9 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset out_product", out_product, 64'd0);
    chk("async reset out_tag", 64'(out_tag), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_one("post-reset 6x7", 32'd6, 32'd7, 3'b100, 4'd5, 64'd42);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("post-reset no stale output", 64'(extra), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/app_mul_pipe.md
Name: app_mul_pipe

Overview:
- Parametrised, pipelined logarithmic (Mitchell) multiplier; successor to the single-cycle combinational approximate multiplier in the core's integer path.
- Three-stage pipeline with a valid/ready handshake, a transaction tag and a per-transaction mode select (unsigned, signed, correction on/off, exact bypass).
- Adds zero-operand detection, true magnitude handling for signed operands, and output saturation.
- Sits between the integer issue stage and writeback. Also used stand-alone in the approximate-computing test harness.

Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH. Legal range 8..64.
- CORR_FRAC, 32'h0A00_0000: error-correction constant as a fraction with WIDTH-1 fractional bits. Default = 0.078125 for WIDTH=32.
- TAG_WIDTH, 4: width of the pass-through transaction tag.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_mode  in  3  [0] signed, [1] correction enable, [2] exact bypass.
- in_tag  in  TAG_WIDTH  tag; returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  product.
- out_tag  out  TAG_WIDTH  tag of this result.
- out_approx  out  1  1 if the result came from the logarithmic path.

Behaviour:
- Reset (asynchronous, reset_n low): all stage valid bits, out_valid, out_product, out_tag and out_approx clear to 0. in_ready reads 1 once reset_n is high. Any in-flight transaction is discarded and never appears at the output.
- Handshake and stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - An input transfers on in_valid && in_ready. An output transfers on out_valid && out_ready.
  - All three stages shift together on advance. When advance=0 every stage holds and out_* stays stable.
  - No bubbles are inserted: back-to-back inputs give back-to-back outputs.
- Latency is exactly 3 cycles from input acceptance to out_valid when unstalled. Throughput is 1 per cycle.
- Stage 1, normalise:
  - If mode[0]=1, take magnitudes |a| and |b| and register neg = a[W-1]^b[W-1]. Otherwise the operands are unsigned and neg=0.
  - Zero flag z = (|a|==0)||(|b|==0).
  - Leading-one detect gives ka and kb. Fractions fa, fb are the WIDTH-1 bits below the leading one, left-aligned.
  - Exact bypass (mode[2]=1): register |a| and |b| for the exact path instead.
- Stage 2, log add:
  - s = fa+fb in WIDTH bits; carry c = s[WIDTH-1].
  - Correction term is CORR_FRAC when c=0 and CORR_FRAC>>1 when c=1; it is 0 when mode[1]=0.
  - m = {1, s[W-2:0]} + correction term, WIDTH+1 bits. If this add overflows, m is shifted right by 1 and k is incremented.
  - k = ka+kb+c.
  - Exact path: full multiply of the magnitudes; the multiply may be split across stages 2-3.
- Stage 3, antilog:
  - p = (m << k) >> (WIDTH-1), truncated toward zero.
  - If p >= 2^(2W), saturate to all ones (unsigned mode only; unreachable in signed mode).
  - If z, p=0 on both paths.
  - If neg, output the two's complement of p; negative zero is 0.
  - out_approx = !mode[2].

Test Plan:
- Unsigned 3*5, WIDTH=32, mode=010 -> 14 (0x0E). Same operands with mode=000 -> 14. Mode=100 -> 15. Each result arrives 3 cycles after acceptance.
- Carry case 3*3, mode=010 -> 8. 4*8 with mode=000 -> 32 (powers of two exact); with mode=010 -> 34.
- Signed -3*5, mode=101 -> 0xFFFF_FFFF_FFFF_FFF1. Same with mode=001 -> -14 (0xFFFF_FFFF_FFFF_FFF2). 0*-7, mode=011 -> 0.
- Stall: stream 8 back-to-back inputs with out_ready held 0 from cycle 2 for 4 cycles -> in_ready drops with out_ready. No result is lost or duplicated; tags come out in order; out_product is stable while stalled.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF, mode=010 -> saturates to 0xFFFF_FFFF_FFFF_FFFF.
- Reset mid-stream: pull reset_n low with 3 transactions in flight -> out_valid=0 asynchronously. After release, a new transaction yields only its own result and tag.
